pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//  Converts 1-clock event pulses (edge-detector outputs) back into held levels of fixed
//  length for LED/buzzer/indicator drive in the stopwatch/FND design. Each accepted pulse
//  yields one HOLD_CYCLES-long high level followed by a GAP_CYCLES low gap. Pulses arriving
//  while a level is active are queued (saturating) so none are lost up to PEND_MAX.
// PARAMETERS
//  HOLD_CYCLES  10  o_level high time per accepted pulse, cycles (>=1)
//  GAP_CYCLES   2   forced low time after each hold, cycles (>=1)
//  PEND_MAX     3   max queued pulses (>=1); pending counter width = $clog2(PEND_MAX+1)
// PORTS
//  clk      in   1  system clock, all logic on posedge
//  rst      in   1  reset, asynchronous, active-low (0 = reset)
//  i_pulse  in   1  event pulse; every high cycle counts as one event
//  o_level  out  1  stretched level output (registered)
//  o_busy   out  1  high whenever state != IDLE
//  o_drop   out  1  1-cycle pulse: event lost because queue was full (registered)
// BEHAVIOUR
//  - Reset (async, rst=0): state=IDLE, timer=0, pending=0, o_level=0, o_drop=0, o_busy=0.
//  - States: IDLE, HOLD, GAP. o_level = 1 exactly in HOLD (registered, no glitches).
//  - IDLE: i_pulse=1 in cycle k -> HOLD, timer=HOLD_CYCLES-1; o_level high from k+1
//    for exactly HOLD_CYCLES cycles. pending untouched (is 0).
//  - HOLD: timer decrements; at timer==0 -> GAP, timer=GAP_CYCLES-1.
//    i_pulse in HOLD: queued (see CONFIGURATION for retrigger variant).
//  - GAP: timer decrements; i_pulse queued. At timer==0 evaluate eff=pending+i_pulse:
//    eff>0 -> HOLD, pending<=eff-1 (pulse on last GAP cycle starts next hold directly,
//    never dropped); eff==0 -> IDLE.
//  - Queue: pending<=pending+1 if <PEND_MAX; if pending==PEND_MAX, event discarded and
//    o_drop=1 for the next cycle. pending never wraps, never exceeds PEND_MAX.
//  - Back-to-back holds always separated by exactly GAP_CYCLES low cycles.
//  - Reset mid-operation: o_level drops immediately (async), queue cleared, no drop pulse.
//  - Timer width = $clog2(max(HOLD_CYCLES,GAP_CYCLES)); all compares unsigned.
// CONFIGURATION
//  PULSE_RETRIGGER_EN defined: i_pulse during HOLD reloads timer=HOLD_CYCLES-1 (level
//   extended, not queued, o_drop never raised from HOLD); GAP behaviour unchanged.
//  Not defined: i_pulse during HOLD queued as above; hold length never extended.
// STRUCTURE
//  - Shared package/include pulse_stretcher_pkg: state encodings (IDLE=2'd0, HOLD=2'd1,
//    GAP=2'd2), timer/pending width helper constants.
//  - One sub-module: hold_timer (load value, load strobe, decrement, zero flag).
//  - Top holds FSM, pending counter, output registers.
// TESTING  (HOLD_CYCLES=10, GAP_CYCLES=2, PEND_MAX=3)
//  1 Single pulse cycle 5 from IDLE -> o_level high cycles 6..15, low 16+, o_busy low
//    from 18, o_drop never.
//  2 Pulses at cycles 5 and 8 (no macro) -> highs 6..15 and 18..27, gap 16..17, pending 1->0.
//  3 Five pulses during one HOLD (no macro) -> 3 queued, 2 o_drop pulses, 4 holds total
//    each 10 high / 2 low.
//  4 Pulse exactly on last GAP cycle, pending=0 -> next hold starts next cycle, no IDLE.
//  5 With PULSE_RETRIGGER_EN: pulses at 5 and 12 -> single level high 6..22, pending=0.
//  6 rst=0 asserted mid-HOLD with pending=2 -> o_level, o_busy 0 same cycle; after release
//    stays IDLE, no further holds, no o_drop.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and width helpers for pulse_stretcher and its hold_timer.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Timer must hold max(HOLD,GAP)-1; floor of one bit keeps 1-cycle configs legal.
    function automatic int timer_w(input int hold_cycles, input int gap_cycles);
        int m;
        m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int pend_w(input int pend_max);
        return $clog2(pend_max + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_hold.sv
// hold_timer: loadable down-counter that parks at zero and flags it.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle event pulses into HOLD_CYCLES-high levels separated by GAP_CYCLES lows,
// queueing up to PEND_MAX extra events. Define PULSE_RETRIGGER_EN to extend the hold instead.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    output logic o_level,
    output logic o_busy,
    output logic o_drop
);

    localparam int TW = timer_w(HOLD_CYCLES, GAP_CYCLES);
    localparam int PW = pend_w(PEND_MAX);
    localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD    = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);
`ifdef PULSE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    state_e        state_q;
    logic [PW-1:0] pend_q;
    logic          level_q;
    logic          drop_q;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_dec;
    logic          tmr_zero;
    logic          start_next;
    logic          queue_ev;

    // A pulse on the final gap cycle feeds straight into the next hold, never the queue.
    assign start_next = (pend_q != '0) || i_pulse;
    assign queue_ev   = i_pulse && (((state_q == HOLD) && !RETRIG) ||
                                    ((state_q == GAP) && !tmr_zero));

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE: tmr_load = i_pulse;
            HOLD: begin
                if (RETRIG && i_pulse) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) tmr_load = start_next;
                else          tmr_dec  = 1'b1;
            end
            default: ;
        endcase
    end

    hold_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            level_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (queue_ev) begin
                if (pend_q != PEND_FULL) pend_q <= pend_q + PW'(1);
                else                     drop_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (i_pulse) begin
                        state_q <= HOLD;
                        level_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr_zero && !(RETRIG && i_pulse)) begin
                        state_q <= GAP;
                        level_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        if (start_next) begin
                            state_q <= HOLD;
                            level_q <= 1'b1;
                            if (!i_pulse) pend_q <= pend_q - PW'(1);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = level_q;
    assign o_drop  = drop_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: spec tables, hand corner sequences, randomized model compare.
module tb_pulse_stretcher;

    localparam int H  = 10;
    localparam int G  = 2;
    localparam int P  = 3;
    localparam int HG = H + G;
`ifdef PULSE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_pulse = 1'b0;
    logic o_level, o_busy, o_drop;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference: one countdown spanning hold+gap; level while more than G cycles remain.
    int m_rem = 0;
    int m_pend = 0;
    bit m_drop = 1'b0;

    typedef struct {
        bit p;
        bit lvl;
        bit busy;
        bit drp;
    } vec_t;
    vec_t tbl[30];

    pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_MAX(P)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_pulse (i_pulse),
        .o_level (o_level),
        .o_busy  (o_busy),
        .o_drop  (o_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_tick(input bit p);
        m_drop = 1'b0;
        if (m_rem == 0) begin
            if (p) m_rem = HG;
        end else if (m_rem == 1) begin
            if (m_pend + int'(p) > 0) begin
                m_rem  = HG;
                m_pend = m_pend + int'(p) - 1;
            end else begin
                m_rem = 0;
            end
        end else if (RETRIG && m_rem > G && p) begin
            m_rem = HG;
        end else begin
            if (p) begin
                if (m_pend < P) m_pend++;
                else            m_drop = 1'b1;
            end
            m_rem--;
        end
    endtask

    // Drive p during cycle cyc; afterwards cyc has advanced and outputs belong to it.
    task automatic step(input bit p);
        i_pulse = p;
        @(posedge clk);
        model_tick(p);
        cyc++;
        @(negedge clk);
        chk("model_level", o_level, 32'(m_rem > G));
        chk("model_busy",  o_busy,  32'(m_rem != 0));
        chk("model_drop",  o_drop,  32'(m_drop));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_pulse = 1'b0;
        #1;
        chk("rst_level", o_level, 0);
        chk("rst_busy",  o_busy,  0);
        chk("rst_drop",  o_drop,  0);
        @(negedge clk);
        rst = 1'b1;
        m_rem = 0; m_pend = 0; m_drop = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int holds, drops, hi, lo;
        bit prev;
        int dens;

        // Test 1: single pulse at cycle 5
        do_reset();
        for (int t = 0; t < 25; t++) begin
            step(cyc == 5);
            chk("t1_level", o_level, 32'(cyc >= 6 && cyc <= 15));
            chk("t1_busy",  o_busy,  32'(cyc >= 6 && cyc <= 17));
            chk("t1_drop",  o_drop,  0);
        end

        // Test 2 (table): pulses at 5 and 8; entry t holds the outputs of cycle t+1
        for (int t = 0; t < 30; t++) begin
            int c;
            c = t + 1;
            tbl[t].p   = (t == 5) || (t == 8);
            tbl[t].drp = 1'b0;
            if (RETRIG) begin
                tbl[t].lvl  = (c >= 6 && c <= 18);
                tbl[t].busy = (c >= 6 && c <= 20);
            end else begin
                tbl[t].lvl  = (c >= 6 && c <= 15) || (c >= 18 && c <= 27);
                tbl[t].busy = (c >= 6 && c <= 29);
            end
        end
        do_reset();
        for (int t = 0; t < 30; t++) begin
            step(tbl[t].p);
            chk("tbl_level", o_level, 32'(tbl[t].lvl));
            chk("tbl_busy",  o_busy,  32'(tbl[t].busy));
            chk("tbl_drop",  o_drop,  32'(tbl[t].drp));
        end
        for (int t = 0; t < 5; t++) step(1'b0);
        chk("t2_idle_busy", o_busy, 0);

        // Test 3: pulse at 5, then five more inside the hold (cycles 6..10)
        do_reset();
        holds = 0; drops = 0; hi = 0; lo = 0; prev = 1'b0;
        for (int t = 0; t < 70; t++) begin
            step(cyc >= 5 && cyc <= 10);
            if (o_level) begin
                if (!prev) begin
                    holds++;
                    if (holds > 1) chk("t3_gap_len", lo, G);
                    hi = 0;
                end
                hi++;
            end else begin
                if (prev) begin
                    chk("t3_hold_len", hi, RETRIG ? 15 : H);
                    lo = 0;
                end
                lo++;
            end
            if (o_drop) drops++;
            prev = o_level;
        end
        chk("t3_holds", holds, RETRIG ? 1 : 4);
        chk("t3_drops", drops, RETRIG ? 0 : 2);
        chk("t3_idle",  o_busy, 0);

        // Test 4: pulse on the last gap cycle (17) starts the next hold at 18
        do_reset();
        while (cyc < 17) step(cyc == 5);
        chk("t4_gap_level", o_level, 0);
        chk("t4_gap_busy",  o_busy,  1);
        step(1'b1);
        chk("t4_next_level", o_level, 1);
        chk("t4_next_busy",  o_busy,  1);
        chk("t4_no_drop",    o_drop,  0);
        while (cyc < 35) step(1'b0);

        // Test 5: pulses at 5 and 12
        do_reset();
        for (int t = 0; t < 35; t++) begin
            step(cyc == 5 || cyc == 12);
            if (RETRIG) chk("t5_level", o_level, 32'(cyc >= 6 && cyc <= 22));
            else        chk("t5_level", o_level, 32'((cyc >= 6 && cyc <= 15) || (cyc >= 18 && cyc <= 27)));
        end

        // Test 6: async reset mid-hold with two pending
        do_reset();
        while (cyc < 10) step(cyc >= 5 && cyc <= 7);
        chk("t6_pre_level", o_level, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_level", o_level, 0);
        chk("t6_async_busy",  o_busy,  0);
        chk("t6_async_drop",  o_drop,  0);
        @(negedge clk);
        rst = 1'b1;
        m_rem = 0; m_pend = 0; m_drop = 1'b0;
        cyc = 0;
        for (int t = 0; t < 40; t++) begin
            step(1'b0);
            chk("t6_post_level", o_level, 0);
        end

        // Randomized traffic at varying pulse densities
        do_reset();
        for (int b = 0; b < 15; b++) begin
            case ($urandom_range(0, 3))
                0: dens = 3;
                1: dens = 15;
                2: dens = 50;
                default: dens = 90;
            endcase
            for (int t = 0; t < 200; t++) step($urandom_range(0, 99) < dens);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
